// File: rtl/spi_adc_pkg.sv
// Shared types and helpers for the SPI ADC receive path.
package spi_adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        DONE
    } spi_adc_state_t;

    localparam int unsigned OVR_CNT_W = 16;

    // Cycles cs_n is held low for one conversion frame.
    function automatic int unsigned frame_len(input int unsigned dw,
                                              input int unsigned sclk_div,
                                              input int unsigned conv_cyc);
        return conv_cyc + 2 * dw * sclk_div;
    endfunction

endpackage

// File: rtl/spi_adc_rx_if.sv
// AXI4-Stream sample channel between the ADC receiver and the DSP chain.
interface spi_adc_rx_if #(
    parameter int unsigned DW = 16
) ();

    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );

endinterface

// File: rtl/spi_adc_rx_counter.sv
// Free-running modulo-MAX counter; co flags the enabled terminal count.
module spi_adc_rx_counter #(
    parameter int unsigned MAX = 96
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic co
);

    localparam int unsigned CW = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign co = en && (cnt_q == LAST);

endmodule

// File: rtl/spi_adc_rx.sv
// Periodic SPI ADC reader: one DW-bit MSB-first conversion per IFREQ cycles onto AXI4-Stream.
// Define SPI_ADC_RX_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module spi_adc_rx
    import spi_adc_pkg::*;
#(
    parameter int unsigned DW       = 16,
    parameter int unsigned IFREQ    = 96,
    parameter int unsigned SCLK_DIV = 1,
    parameter int unsigned CONV_CYC = 8
) (
    input  logic        m_axis_aclk,
    input  logic        m_axis_areset,
    input  logic        en,
    input  logic        sdo,
    output logic        sclk,
    output logic        cs_n,
    output logic        overrun,
`ifdef SPI_ADC_RX_OVERRUN_CNT_EN
    output logic [15:0] overrun_cnt,
`endif
    spi_adc_rx_if.master m_axis
);

    if (IFREQ < frame_len(DW, SCLK_DIV, CONV_CYC) + 2) begin : g_cfg_check
        $error("spi_adc_rx: IFREQ shorter than one conversion frame plus two cycles");
    end

    // One cycle counter serves both the CONV hold and the per-bit sclk phase.
    localparam int unsigned CMAX = (CONV_CYC > 2 * SCLK_DIV) ? CONV_CYC : 2 * SCLK_DIV;
    localparam int unsigned CW   = $clog2(CMAX) + 1;
    localparam int unsigned BW   = $clog2(DW);

    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(2 * SCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_MAX   = BW'(DW - 1);

    spi_adc_state_t state_q;
    logic [CW-1:0]  cyc_q;
    logic [BW-1:0]  bit_q;
    logic [DW-1:0]  shreg_q;
    logic [DW-1:0]  tdata_q;
    logic           tvalid_q;
    logic           sclk_q;
    logic           cs_n_q;
    logic           overrun_q;
    logic           tick;

    spi_adc_rx_counter #(
        .MAX (IFREQ)
    ) theCounterPeriod (
        .clk (m_axis_aclk),
        .rst (m_axis_areset),
        .en  (en),
        .co  (tick)
    );

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (tvalid_q && m_axis.tready) begin
                tvalid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q <= CONV;
                        cs_n_q  <= 1'b0;
                        cyc_q   <= '0;
                    end
                end
                CONV: begin
                    if (cyc_q == CONV_LAST) begin
                        state_q <= SHIFT;
                        cyc_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                SHIFT: begin
                    // Capture coincides with the rising sclk the ADC sees.
                    if (cyc_q == HALF_LAST) begin
                        sclk_q  <= 1'b1;
                        shreg_q <= {shreg_q[DW-2:0], sdo};
                    end
                    if (cyc_q == BIT_LAST) begin
                        sclk_q <= 1'b0;
                        cyc_q  <= '0;
                        if (bit_q == BIT_MAX) begin
                            cs_n_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                DONE: begin
                    // Newest sample wins; an accept in this cycle takes the old one.
                    tdata_q   <= shreg_q;
                    tvalid_q  <= 1'b1;
                    overrun_q <= tvalid_q && !m_axis.tready;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign sclk          = sclk_q;
    assign cs_n          = cs_n_q;
    assign overrun       = overrun_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;

`ifdef SPI_ADC_RX_OVERRUN_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_cnt_q;

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            ovr_cnt_q <= '0;
        end else if (overrun_q && (ovr_cnt_q != {OVR_CNT_W{1'b1}})) begin
            ovr_cnt_q <= ovr_cnt_q + 1'b1;
        end
    end

    assign overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_spi_adc_rx.sv
// Self-checking bench for spi_adc_rx: directed frame sequences, a vector table and a random
// handshake phase against a frame-level model; a second instance covers SCLK_DIV=3.
module tb_spi_adc_rx;

    localparam int DW     = 16;
    localparam int IFREQ  = 96;
    localparam int SDIV   = 1;
    localparam int CONV   = 8;
    localparam int FRAME  = CONV + 2 * DW * SDIV;
    localparam int IFREQ6 = 110;
    localparam int SDIV6  = 3;
    localparam int CONV6  = 4;
    localparam int FRAME6 = CONV6 + 2 * DW * SDIV6;
    localparam int RAND_CYC = 96 * 12;

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_data;
        int          exp_gap;
    } vec_t;

    logic clk = 1'b0;
    logic rst, en, en6, sdo, sdo6, sclk, sclk6, cs_n, cs6, overrun, overrun6;
    logic [15:0] adc_word, adc6_word, frame_word, frame6_word;
    int falls, fall_base, falls6, fall_base6;
    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int ovr_pulses = 0;
`ifdef SPI_ADC_RX_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt, ovr_cnt6;
`endif

    spi_adc_rx_if #(.DW(DW)) m_if ();
    spi_adc_rx_if #(.DW(DW)) if6 ();

    spi_adc_rx #(.DW(DW), .IFREQ(IFREQ), .SCLK_DIV(SDIV), .CONV_CYC(CONV)) dut (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .en            (en),
        .sdo           (sdo),
        .sclk          (sclk),
        .cs_n          (cs_n),
        .overrun       (overrun),
`ifdef SPI_ADC_RX_OVERRUN_CNT_EN
        .overrun_cnt   (ovr_cnt),
`endif
        .m_axis        (m_if)
    );

    spi_adc_rx #(.DW(DW), .IFREQ(IFREQ6), .SCLK_DIV(SDIV6), .CONV_CYC(CONV6)) dut6 (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .en            (en6),
        .sdo           (sdo6),
        .sclk          (sclk6),
        .cs_n          (cs6),
        .overrun       (overrun6),
`ifdef SPI_ADC_RX_OVERRUN_CNT_EN
        .overrun_cnt   (ovr_cnt6),
`endif
        .m_axis        (if6)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;
    always @(negedge clk) if (overrun === 1'b1) ovr_pulses++;

    // ADC model: latch the word on cs_n fall, present bit DW-1-k after k sclk falls.
    always @(negedge cs_n) begin
        frame_word = adc_word;
        fall_base  = falls;
    end
    always @(negedge sclk) falls++;
    always @* begin
        int idx;
        idx = falls - fall_base;
        sdo = (idx >= 0 && idx < DW) ? frame_word[DW-1-idx] : 1'b0;
    end

    always @(negedge cs6) begin
        frame6_word = adc6_word;
        fall_base6  = falls6;
    end
    always @(negedge sclk6) falls6++;
    always @* begin
        int idx;
        idx = falls6 - fall_base6;
        sdo6 = (idx >= 0 && idx < DW) ? frame6_word[DW-1-idx] : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // sel: 0 cs_n, 1 tvalid, 2 overrun, 3 cs6, 4 tvalid6
    task automatic wait_sig(input string name, input int sel, input logic lvl, input int budget,
                            output int n);
        logic v;
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            case (sel)
                0:       v = cs_n;
                1:       v = m_if.tvalid;
                2:       v = overrun;
                3:       v = cs6;
                default: v = if6.tvalid;
            endcase
            if (v === lvl) begin
                n = k;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout after %0d cycles waiting for level %0b", name, budget, lvl);
    endtask

    // Entered at the first negedge with cs low; returns at the first negedge with cs high.
    task automatic measure(input bit sel, output int low, output int pulses,
                           output int hmin, output int hmax, output int lmin, output int lmax);
        logic pc, sc, cs;
        int hrun, lrun;
        low = 1; pulses = 0; hrun = 0; lrun = 0;
        hmin = 999; hmax = 0; lmin = 999; lmax = 0;
        pc = sel ? sclk6 : sclk;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            cs = sel ? cs6 : cs_n;
            sc = sel ? sclk6 : sclk;
            if (sc && !pc) begin
                pulses++;
                if (pulses > 1) begin
                    if (lrun < lmin) lmin = lrun;
                    if (lrun > lmax) lmax = lrun;
                end
                lrun = 0;
            end
            if (!sc && pc) begin
                if (hrun < hmin) hmin = hrun;
                if (hrun > hmax) hmax = hrun;
                hrun = 0;
            end
            if (sc) hrun++;
            else lrun++;
            pc = sc;
            if (cs) break;
            low++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[4];
        int n, low, pulses, hmin, hmax, lmin, lmax, last_cyc, rises, falls_seen, got_n;
        logic [15:0] got_d, m_td;
        logic ps, prev_cs, done_now, m_tv, m_ovr;

        tbl[0] = '{16'h0001, 16'h0001, IFREQ};
        tbl[1] = '{16'h8000, 16'h8000, IFREQ};
        tbl[2] = '{16'hFFFF, 16'hFFFF, IFREQ};
        tbl[3] = '{16'h5A5A, 16'h5A5A, IFREQ};

        rst = 1'b1; en = 1'b0; en6 = 1'b0;
        m_if.tready = 1'b0; if6.tready = 1'b1;
        adc_word = 16'hA5C3; adc6_word = 16'hC3A5;
        falls = 0; fall_base = 0; falls6 = 0; fall_base6 = 0;
        frame_word = '0; frame6_word = '0;
        repeat (3) @(negedge clk);
        chk("reset cs_n", cs_n, 1);
        chk("reset sclk", sclk, 0);
        chk("reset tvalid", m_if.tvalid, 0);
        chk("reset tdata", m_if.tdata, 0);
        chk("reset overrun", overrun, 0);
        rst = 1'b0; en = 1'b1;

        // 1: single frame, timing and data
        wait_sig("t1 cs fall", 0, 1'b0, 200, n);
        chk("t1 first period", n, IFREQ);
        measure(1'b0, low, pulses, hmin, hmax, lmin, lmax);
        chk("t1 cs low cycles", low, FRAME);
        chk("t1 sclk pulses", pulses, DW);
        chk("t1 sclk high len", hmax, SDIV);
        chk("t1 sclk low len", lmin, SDIV);
        chk("t1 tvalid early", m_if.tvalid, 0);
        @(negedge clk);
        chk("t1 tvalid", m_if.tvalid, 1);
        chk("t1 tdata", m_if.tdata, 16'hA5C3);
        m_if.tready = 1'b1;
        @(negedge clk);
        chk("t1 tvalid drop", m_if.tvalid, 0);
        chk("t1 no overrun", ovr_pulses, 0);

        // 2: back-to-back periods with tready high
        last_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            adc_word = tbl[i].word;
            wait_sig("t2 tvalid", 1, 1'b1, 200, n);
            chk("t2 tdata", m_if.tdata, tbl[i].exp_data);
            if (i > 0) chk("t2 gap", cyc_n - last_cyc, tbl[i].exp_gap);
            last_cyc = cyc_n;
            @(negedge clk);
            chk("t2 tvalid drop", m_if.tvalid, 0);
        end
        chk("t2 no overrun", ovr_pulses, 0);

        // 3: two frames unaccepted
        m_if.tready = 1'b0;
        adc_word = 16'h1111;
        wait_sig("t3 tvalid", 1, 1'b1, 200, n);
        chk("t3 first tdata", m_if.tdata, 16'h1111);
        adc_word = 16'h2222;
        wait_sig("t3 overrun", 2, 1'b1, 200, n);
        chk("t3 tdata newest", m_if.tdata, 16'h2222);
        chk("t3 tvalid held", m_if.tvalid, 1);
        @(negedge clk);
        chk("t3 overrun pulse", overrun, 0);
        m_if.tready = 1'b1;
        @(negedge clk);
        chk("t3 accepted", m_if.tvalid, 0);
        chk("t3 overrun count", ovr_pulses, 1);
`ifdef SPI_ADC_RX_OVERRUN_CNT_EN
        chk("t3 overrun_cnt", ovr_cnt, 1);
`endif

        // 4: reset in bit 7 of SHIFT
        adc_word = 16'h3C5A;
        wait_sig("t4 cs fall", 0, 1'b0, 200, n);
        rises = 0;
        ps = sclk;
        for (int k = 0; k < 200 && rises < 7; k++) begin
            @(negedge clk);
            if (sclk && !ps) rises++;
            ps = sclk;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4 cs_n", cs_n, 1);
        chk("t4 sclk", sclk, 0);
        chk("t4 tvalid", m_if.tvalid, 0);
        chk("t4 tdata", m_if.tdata, 0);
        rst = 1'b0;
        adc_word = 16'hBEEF;
        wait_sig("t4 cs restart", 0, 1'b0, 200, n);
        chk("t4 restart period", n, IFREQ);
        wait_sig("t4 tvalid", 1, 1'b1, 100, n);
        chk("t4 tdata after", m_if.tdata, 16'hBEEF);
        @(negedge clk);

        // 5: en dropped at CONV cycle 3
        adc_word = 16'h6789;
        wait_sig("t5 cs fall", 0, 1'b0, 200, n);
        repeat (3) @(negedge clk);
        en = 1'b0;
        prev_cs = cs_n; falls_seen = 0; got_n = 0; got_d = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!cs_n && prev_cs) falls_seen++;
            prev_cs = cs_n;
            if (m_if.tvalid && m_if.tready) begin
                got_n++;
                got_d = m_if.tdata;
            end
        end
        chk("t5 deliveries", got_n, 1);
        chk("t5 tdata", got_d, 16'h6789);
        chk("t5 cs activity", falls_seen, 0);
        adc_word = 16'h0F0F;
        en = 1'b1;
        wait_sig("t5 resume", 0, 1'b0, 200, n);
        chk("t5 resume period", n, IFREQ - 3);
        wait_sig("t5 tvalid", 1, 1'b1, 100, n);
        chk("t5 tdata after", m_if.tdata, 16'h0F0F);
        @(negedge clk);

        // Random tready and words against a frame-level handshake model
        m_tv = 1'b0; m_td = 16'h0F0F; prev_cs = cs_n;
        adc_word = 16'($urandom);
        for (int c = 0; c < RAND_CYC; c++) begin
            done_now = cs_n && !prev_cs;
            prev_cs = cs_n;
            m_if.tready = ($urandom_range(0, 127) == 0);
            if (done_now) begin
                m_ovr = m_tv && !m_if.tready;
                m_tv  = 1'b1;
                m_td  = frame_word;
                adc_word = 16'($urandom);
            end else begin
                m_ovr = 1'b0;
                if (m_tv && m_if.tready) m_tv = 1'b0;
            end
            @(negedge clk);
            chk("rnd tvalid", m_if.tvalid, m_tv);
            chk("rnd tdata", m_if.tdata, m_td);
            chk("rnd overrun", overrun, m_ovr);
        end

        // 6: SCLK_DIV=3, CONV_CYC=4, IFREQ=110 instance
        en6 = 1'b1;
        wait_sig("t6 cs fall", 3, 1'b0, 300, n);
        chk("t6 first period", n, IFREQ6);
        measure(1'b1, low, pulses, hmin, hmax, lmin, lmax);
        chk("t6 cs low cycles", low, FRAME6);
        chk("t6 sclk pulses", pulses, DW);
        chk("t6 sclk high min", hmin, SDIV6);
        chk("t6 sclk high max", hmax, SDIV6);
        chk("t6 sclk low min", lmin, SDIV6);
        chk("t6 sclk low max", lmax, SDIV6);
        wait_sig("t6 tvalid", 4, 1'b1, 20, n);
        chk("t6 tvalid delay", n, 1);
        chk("t6 tdata", if6.tdata, 16'hC3A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
